// File: rtl/act_mem_pkg.sv
// Shared activation-memory constants, packer FSM states and the precision-mode decode
// used by both the write-side packer and the read-side unpack mux.
package act_mem_pkg;

  localparam int PMAX        = 8;
  localparam int PMIN        = 2;
  localparam int NUM_BANKS   = PMAX / PMIN;
  localparam int DATA_WIDTH  = PMAX * NUM_BANKS;
  localparam int PMODE_WIDTH = $clog2(NUM_BANKS);
  localparam int MAX_MODE    = $clog2(PMAX / PMIN);
  localparam int EW_W        = $clog2(PMAX) + 1;
  localparam int EPW_W       = $clog2(DATA_WIDTH / PMIN) + 1;
  localparam int CNT_W       = $clog2(DATA_WIDTH / PMIN);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  typedef struct packed {
    logic [EW_W-1:0]  ew;
    logic [EPW_W-1:0] epw;
  } prec_cfg_t;

  // Modes beyond the narrowest legal precision fall back to PMIN-bit elements.
  function automatic logic [PMODE_WIDTH-1:0] eff_mode(input logic [PMODE_WIDTH-1:0] mode);
    return (int'(mode) > MAX_MODE) ? PMODE_WIDTH'(MAX_MODE) : mode;
  endfunction

  function automatic prec_cfg_t mode_cfg(input logic [PMODE_WIDTH-1:0] mode);
    prec_cfg_t cfg;
    cfg.ew  = EW_W'(PMAX >> eff_mode(mode));
    cfg.epw = EPW_W'(NUM_BANKS << eff_mode(mode));
    return cfg;
  endfunction

endpackage

// File: rtl/act_lane_insert.sv
// Combinational lane write: drops an ew-bit element into lane cnt of a DATA_WIDTH word,
// masking off element bits above ew and leaving all other lanes untouched.
module act_lane_insert
  import act_mem_pkg::*;
(
  input  logic [EW_W-1:0]       ew_i,
  input  logic [CNT_W-1:0]      cnt_i,
  input  logic [PMAX-1:0]       elem_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0]       sh;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] elem_w;

  always_comb begin
    mask   = (DATA_WIDTH'(1) << ew_i) - DATA_WIDTH'(1);
    sh     = SH_W'(cnt_i) * SH_W'(ew_i);
    elem_w = DATA_WIDTH'(elem_i) & mask;
    word_o = (word_i & ~(mask << sh)) | (elem_w << sh);
  end

endmodule

// File: rtl/act_mem_packer.sv
// Packs a precision-mode element stream into DATA_WIDTH words written from base_addr; wr_valid rises the cycle after a word's last element.
// wr_data/wr_addr hold under wr_ready backpressure; define ACT_PACKER_SKID_EN for a ping-pong buffer that keeps in_ready high during writes.
module act_mem_packer
  import act_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PMODE_WIDTH-1:0]    precision_mode,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PMAX-1:0]           in_data,
  input  logic                      in_last,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      done,
  output logic                      busy
);

  state_e                    state_q, state_d;
  prec_cfg_t                 cfg_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]     fbuf_q;
  logic [DATA_WIDTH-1:0]     ins_word;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      acc;
  logic                      hs;
  logic                      word_end;
  logic                      run_start;

  act_lane_insert u_lane_insert (
    .ew_i   (cfg_q.ew),
    .cnt_i  (cnt_q),
    .elem_i (in_data),
    .word_i (fbuf_q),
    .word_o (ins_word)
  );

  assign run_start = (state_q == IDLE) && start;
  assign acc       = in_valid && in_ready;
  assign hs        = wr_valid && wr_ready;
  assign word_end  = acc && (in_last || (EPW_W'(cnt_q) == cfg_q.epw - EPW_W'(1)));
  assign wr_addr   = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef ACT_PACKER_SKID_EN
  // fbuf_q fills while wbuf_q is offered to memory; a completed fill word waits in fbuf_q (ffull_q) until the slot frees.
  logic [DATA_WIDTH-1:0] wbuf_q;
  logic                  wlast_q, ffull_q, flast_q, seen_last_q;
  logic                  slot_free, move, move_last, wvld_d;
  logic [DATA_WIDTH-1:0] move_word;

  assign slot_free = (state_q != WRITE) || hs;
  assign move      = slot_free && (ffull_q || word_end);
  assign move_word = ffull_q ? fbuf_q : ins_word;
  assign move_last = ffull_q ? flast_q : in_last;
  assign wvld_d    = move || ((state_q == WRITE) && !hs);
  assign wr_data   = wbuf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start) state_d = FILL;
      FILL, WRITE: begin
        if (hs && wlast_q) state_d = DONE;
        else if (wvld_d)   state_d = WRITE;
        else               state_d = FILL;
      end
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = ((state_q == FILL) || (state_q == WRITE)) && !ffull_q && !seen_last_q;
    wr_valid = (state_q == WRITE);
    done     = (state_q == DONE);
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q       <= '0;
      cnt_q       <= '0;
      fbuf_q      <= '0;
      addr_q      <= '0;
      wbuf_q      <= '0;
      wlast_q     <= 1'b0;
      ffull_q     <= 1'b0;
      flast_q     <= 1'b0;
      seen_last_q <= 1'b0;
    end else begin
      if (run_start) begin
        cfg_q       <= mode_cfg(precision_mode);
        addr_q      <= base_addr;
        cnt_q       <= '0;
        fbuf_q      <= '0;
        ffull_q     <= 1'b0;
        flast_q     <= 1'b0;
        seen_last_q <= 1'b0;
      end
      if (acc) begin
        seen_last_q <= in_last;
        cnt_q       <= word_end ? '0 : cnt_q + CNT_W'(1);
        fbuf_q      <= (word_end && move) ? '0 : ins_word;
        if (word_end && !move) begin
          ffull_q <= 1'b1;
          flast_q <= in_last;
        end
      end
      if (ffull_q && move) begin
        fbuf_q  <= '0;
        ffull_q <= 1'b0;
      end
      if (move) begin
        wbuf_q  <= move_word;
        wlast_q <= move_last;
      end else if (hs) begin
        wbuf_q  <= '0;
      end
      if (hs) addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
    end
  end
`else
  logic last_q;

  assign wr_data = fbuf_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (word_end) state_d = WRITE;
      WRITE:   if (hs) state_d = last_q ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == FILL);
    wr_valid = (state_q == WRITE);
    done     = (state_q == DONE);
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      fbuf_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (run_start) begin
        cfg_q  <= mode_cfg(precision_mode);
        addr_q <= base_addr;
        cnt_q  <= '0;
        fbuf_q <= '0;
      end
      if (acc) begin
        fbuf_q <= ins_word;
        cnt_q  <= cnt_q + CNT_W'(1);
        last_q <= in_last;
      end
      if (hs) begin
        fbuf_q <= '0;
        cnt_q  <= '0;
        addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_act_mem_packer.sv
// Bench for act_mem_packer: fixed vector table, hand-written backpressure/reset sequences,
// and randomized runs against a word-level packing model.
module tb_act_mem_packer;
  import act_mem_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [PMODE_WIDTH-1:0] precision_mode = '0;
  logic [9:0]             base_addr = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [PMAX-1:0]        in_data = '0;
  logic                   in_last = 1'b0;
  logic                   wr_valid;
  logic                   wr_ready = 1'b0;
  logic [9:0]             wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   done;
  logic                   busy;

  always #5 clk = ~clk;

  act_mem_packer #(.MEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .precision_mode(precision_mode),
    .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .busy(busy)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          mode;
    int          base;
    int          n;
    logic [31:0] el_lst;
    bit          cyc;
    int          exp_words;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [9:0]  a1;
    logic [31:0] d1;
  } vec_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  stim_q[$];
  int  idx;
  wr_t got_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int ew_of(input int mode);
    return 8 >> ((mode > 2) ? 2 : mode);
  endfunction

  task automatic start_run(input int mode, input int base);
    start          = 1'b1;
    precision_mode = 2'(mode);
    base_addr      = 10'(base);
    in_valid       = 1'b0;
    wr_ready       = 1'b0;
    @(negedge clk);
    start          = 1'b0;
    precision_mode = 2'($urandom);
    base_addr      = 10'($urandom);
    idx            = 0;
    got_q.delete();
  endtask

  // Runs the stream to completion; ok reports that done came exactly one cycle after the final write handshake.
  task automatic drive_until_done(input int rdy_pct, input int vld_pct, input int mode, output bit ok);
    int last_hs;
    int ew;
    wr_t w;
    last_hs = -10;
    ok      = 1'b0;
    ew      = ew_of(mode);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        ok = (last_hs == cyc - 1);
        break;
      end
      in_valid = (idx < stim_q.size()) && ($urandom_range(99) < vld_pct);
      in_data  = in_valid ? 8'((stim_q[idx] & ((1 << ew) - 1)) | ($urandom << ew)) : 8'($urandom);
      in_last  = in_valid && (idx == stim_q.size() - 1);
      wr_ready = ($urandom_range(99) < rdy_pct);
      if (in_valid && in_ready) idx++;
      if (wr_valid && wr_ready) begin
        w.addr = wr_addr;
        w.data = wr_data;
        got_q.push_back(w);
        last_hs = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wr_ready = 1'b0;
  endtask

  task automatic end_checks(input string nm, input bit ok);
    chk({nm, " done_timing"}, 64'(ok), 1);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " busy_after"}, busy, 0);
  endtask

  // Reference: word w holds elements w*EPW .. w*EPW+EPW-1, element j at bit j*ew; address is base+w mod 1024.
  task automatic compare_words(input string nm, input int mode, input int base);
    int ew, epw, n, nw;
    logic [31:0] d;
    ew  = ew_of(mode);
    epw = 32 / ew;
    n   = stim_q.size();
    nw  = (n + epw - 1) / epw;
    chk({nm, " words"}, got_q.size(), nw);
    for (int w = 0; w < nw && w < got_q.size(); w++) begin
      d = '0;
      for (int j = 0; j < epw; j++)
        if (w * epw + j < n) d = d | (32'(stim_q[w * epw + j] & ((1 << ew) - 1)) << (j * ew));
      chk({nm, " addr"}, got_q[w].addr, 64'((base + w) % 1024));
      chk({nm, " data"}, got_q[w].data, d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    bit   ok;
    bit   exp_rdy;
    int   mode, base, n;

    vt[0] = '{0, 'h010, 4,  32'h44332211, 1'b0, 1, 10'h010, 32'h44332211, 10'h000, 32'h0};
    vt[1] = '{2, 'h080, 32, 32'h0,        1'b1, 2, 10'h080, 32'hE4E4E4E4, 10'h081, 32'hE4E4E4E4};
    vt[2] = '{1, 'h200, 3,  32'h000C0B0A, 1'b0, 1, 10'h200, 32'h00000CBA, 10'h000, 32'h0};
    vt[3] = '{3, 'h3FF, 32, 32'h0,        1'b1, 2, 10'h3FF, 32'hE4E4E4E4, 10'h000, 32'hE4E4E4E4};
    vt[4] = '{0, 'h005, 4,  32'h018000FF, 1'b0, 1, 10'h005, 32'h018000FF, 10'h000, 32'h0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset wr_valid", wr_valid, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // Fixed vectors
    for (int r = 0; r < 5; r++) begin
      stim_q.delete();
      for (int i = 0; i < vt[r].n; i++)
        stim_q.push_back(vt[r].cyc ? (i % 4) : int'((vt[r].el_lst >> (8 * i)) & 32'hFF));
      start_run(vt[r].mode, vt[r].base);
      drive_until_done(100, 100, vt[r].mode, ok);
      chk("vec words", got_q.size(), vt[r].exp_words);
      if (got_q.size() > 0) begin
        chk("vec addr0", got_q[0].addr, vt[r].a0);
        chk("vec data0", got_q[0].data, vt[r].d0);
      end
      if (vt[r].exp_words > 1 && got_q.size() > 1) begin
        chk("vec addr1", got_q[1].addr, vt[r].a1);
        chk("vec data1", got_q[1].data, vt[r].d1);
      end
      end_checks("vec", ok);
    end

    // Backpressure: first word stalls for 5 cycles while the stream keeps offering data
    stim_q.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(i);
    start_run(0, 'h100);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(stim_q[idx]);
      in_last  = 1'b0;
      wr_ready = 1'b0;
      chk("bp fill in_ready", in_ready, 1);
      if (in_ready) idx++;
      @(negedge clk);
    end
    chk("bp latency wr_valid", wr_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = (idx < 8);
      in_data  = (idx < 8) ? 8'(stim_q[idx]) : 8'h00;
      in_last  = (idx == 7);
      wr_ready = 1'b0;
`ifdef ACT_PACKER_SKID_EN
      exp_rdy = (k < 4);
`else
      exp_rdy = 1'b0;
`endif
      chk("bp hold wr_valid", wr_valid, 1);
      chk("bp hold wr_data", wr_data, 32'h04030201);
      chk("bp hold wr_addr", wr_addr, 10'h100);
      chk("bp in_ready", in_ready, exp_rdy);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    drive_until_done(100, 100, 0, ok);
    compare_words("bp", 0, 'h100);
    end_checks("bp", ok);

    // Reset in the middle of a write, then a clean run with an ignored start while busy
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'h51 + i);
    start_run(0, 'h020);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(stim_q[idx]);
      in_last  = (k == 3);
      wr_ready = 1'b0;
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rst pre wr_valid", wr_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst wr_valid", wr_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst wr_addr", wr_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'hA1 + i);
    start_run(0, 'h040);
    start          = 1'b1;
    base_addr      = 10'h200;
    precision_mode = 2'd2;
    @(negedge clk);
    start = 1'b0;
    drive_until_done(100, 100, 0, ok);
    compare_words("post rst", 0, 'h040);
    chk("post rst data", (got_q.size() > 0) ? 64'(got_q[0].data) : 64'h0, 32'hA4A3A2A1);
    chk("post rst addr hold", wr_addr, 10'h041);
    end_checks("post rst", ok);

    // Randomized runs against the packing model
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(3);
      base = $urandom_range(1023);
      n    = $urandom_range(40, 1);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back($urandom_range(255));
      start_run(mode, base);
      drive_until_done($urandom_range(100, 30), $urandom_range(100, 50), mode, ok);
      compare_words("rand", mode, base);
      end_checks("rand", ok);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/act_mem_packer.md
Name: act_mem_packer

Overview:
- Write-side counterpart of the activation-memory read path, which reads NUM_BANKS banks and unpacks words by precision mode.
- Accepts a stream of activation elements at the run's precision and packs them into DATA_WIDTH memory words, first element in the LSBs.
- Issues sequential bank-word writes from a base address.
- Sits between the output/activation writeback logic and the activation SRAM.

Parameters:
- PMAX, 8, max element precision in bits.
- PMIN, 2, min element precision in bits.
- NUM_BANKS, PMAX/PMIN, number of SRAM banks.
- DATA_WIDTH, PMAX*NUM_BANKS, memory word width.
- PMODE_WIDTH, $clog2(NUM_BANKS), precision-mode width.
- MEM_ADDR_WIDTH, 10, word address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; honoured only in IDLE.
- precision_mode  in  PMODE_WIDTH  element width is PMAX>>mode; modes above log2(PMAX/PMIN) are treated as PMIN.
- base_addr  in  MEM_ADDR_WIDTH  first write address.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid&&in_ready.
- in_data  in  PMAX  element, right-aligned; upper bits ignored.
- in_last  in  1  final element of the run.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  MEM_ADDR_WIDTH  write address.
- wr_data  out  DATA_WIDTH  packed word.
- done  out  1  one-cycle pulse after the last word is accepted.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, done=0, busy=0; state=IDLE, lane count=0.
- Config latch: in IDLE, a start pulse latches the effective mode (ew = element width, EPW = DATA_WIDTH/ew elements per word) and base_addr, then moves to FILL. start outside IDLE is ignored.
- FILL: in_ready=1. Each accepted element is masked to ew bits and written to bits [cnt*ew +: ew]; cnt increments.
  - If cnt==EPW-1 or in_last is set, go to WRITE and remember last_seen=in_last.
  - Unfilled lanes are zero.
- WRITE: wr_valid=1 and in_ready=0 (see optional feature). wr_data and wr_addr stay stable until wr_ready.
  - On handshake: wr_addr increments modulo 2^MEM_ADDR_WIDTH (0x3FF to 0x000), buffer clears, cnt=0.
  - Then go to DONE if last_seen, else FILL.
- DONE: done=1 for one cycle, then IDLE. wr_addr holds its last value plus one.
- Latency: last element of a word accepted in cycle N → wr_valid high in cycle N+1.
- Simultaneous events: in_last on the EPW-th element yields a single full word, with no extra empty word.
- Reset: assertion at any point (including mid-WRITE) immediately drops wr_valid/in_ready and returns to IDLE. A partially packed word is discarded.
- No zero-length run: in_last is the only terminator.

Optional Feature:
- Macro ACT_PACKER_SKID_EN.
- When defined: a second pack buffer (ping-pong) is added. in_ready stays high during WRITE while the alternate buffer is not full, giving sustained one element per cycle with no bubble at word boundaries. Word order and addresses are unchanged. done fires after the final buffer's handshake.
- When undefined: single buffer, one-cycle-minimum input bubble per word, as described in Behaviour.

Decomposition:
- Package act_mem_pkg holds:
  - the state enum {IDLE, FILL, WRITE, DONE};
  - constants PMAX, PMIN, NUM_BANKS, DATA_WIDTH, PMODE_WIDTH;
  - a function mapping mode to ew and EPW, shared with the read-side mux.
- One sub-module, act_lane_insert: a combinational write of an ew-bit element at lane cnt into a DATA_WIDTH word for the current mode. The FSM, counters and (optional) second buffer stay in the top.

Test Plan:
- Mode 0, base 0x010, elements 0x11,0x22,0x33,0x44 (last on 0x44) → one write: addr 0x010, data 0x44332211; done pulses 1 cycle after the handshake.
- Mode 2, 32 elements cycling 0,1,2,3, last on #32 → two writes, both data 0xE4E4E4E4, at addrs base and base+1.
- Mode 1, elements 0xA,0xB,0xC with last on 0xC → data 0x00000CBA (zero-padded), single write, done.
- Backpressure: wr_ready low for 5 cycles → wr_data/wr_addr stable and wr_valid held. in_ready=0 without skid; with ACT_PACKER_SKID_EN, in_ready=1 until the second buffer fills.
- Wrap plus illegal mode: base 0x3FF, mode 3, 32 elements → behaves as mode 2, writes to 0x3FF then 0x000.
- Reset asserted mid-WRITE → wr_valid=0 in the same cycle. After release, a start with 4 elements in mode 0 writes cleanly at the new base; start while busy is ignored.
